// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB over a shared
// ALU, unified memory port and register file, plus a retired-instruction counter.
module multicycle_control_fsm #(
    parameter logic [2:0] RESET_STATE = 3'd0,
    parameter int         INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          inst,
    input  logic                 BrEq,
    input  logic                 BrLt,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 PCSel,
    output logic                 RegWEn,
    output logic                 BrUn,
    output logic                 ASel,
    output logic                 BSel,
    output logic                 MemRW,
    output logic [1:0]           WBSel,
    output logic [2:0]           ImmSel,
    output logic [3:0]           ALUSel,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_S, C_B, C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD
    } iclass_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [INSTRET_W-1:0] ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

    state_t      state, next_state;
    iclass_t     cls;
    logic        retire;
    logic        taken;
    logic [2:0]  funct3;
    logic [3:0]  alu_arith;
    logic        unused_inst_bits;

    assign funct3 = inst[14:12];
    assign unused_inst_bits = ^{inst[31], inst[29:15], inst[11:7], inst[1:0]};

    always_comb begin
        case (inst[6:2])
            5'b01100: cls = C_R;
            5'b00100: cls = C_I;
            5'b00000: cls = C_LOAD;
            5'b01000: cls = C_S;
            5'b11000: cls = C_B;
            5'b11011: cls = C_JAL;
            5'b11001: cls = C_JALR;
            5'b01101: cls = C_LUI;
            5'b00101: cls = C_AUIPC;
            default:  cls = C_BAD;
        endcase
    end

    // inst[30] selects SUB only for R-type; for shifts it selects SRA/SRAI in both
    always_comb begin
        case (funct3)
            3'b000:  alu_arith = (cls == C_R && inst[30]) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_arith = ALU_SLL;
            3'b010:  alu_arith = ALU_SLT;
            3'b011:  alu_arith = ALU_SLTU;
            3'b100:  alu_arith = ALU_XOR;
            3'b101:  alu_arith = inst[30] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_arith = ALU_OR;
            default: alu_arith = ALU_AND;
        endcase
    end

    // funct3[2] picks BrLt over BrEq, funct3[0] inverts (BNE/BGE/BGEU)
    assign taken = funct3[2] ? (BrLt ^ funct3[0]) : (BrEq ^ funct3[0]);

    always_comb begin
        mem_req    = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSel      = 1'b0;
        RegWEn     = 1'b0;
        BrUn       = 1'b0;
        ASel       = 1'b0;
        BSel       = 1'b0;
        MemRW      = 1'b0;
        WBSel      = 2'd0;
        ImmSel     = IMM_I;
        ALUSel     = ALU_ADD;
        illegal    = 1'b0;
        retire     = 1'b0;
        next_state = state;

        if (!rst) begin
            // ALU/immediate selects stay stable from EXEC through MEM and WB
            if (state == EXEC || state == MEM || state == WB) begin
                case (cls)
                    C_R:     ALUSel = alu_arith;
                    C_I:     begin ALUSel = alu_arith; BSel = 1'b1; end
                    C_LOAD:  begin BSel = 1'b1; ImmSel = IMM_I; end
                    C_S:     begin BSel = 1'b1; ImmSel = IMM_S; end
                    C_B:     begin ASel = 1'b1; BSel = 1'b1; ImmSel = IMM_B; end
                    C_JAL:   begin ASel = 1'b1; BSel = 1'b1; ImmSel = IMM_J; end
                    C_JALR:  begin BSel = 1'b1; ImmSel = IMM_I; end
                    C_LUI:   begin BSel = 1'b1; ImmSel = IMM_U; ALUSel = ALU_PASSB; end
                    C_AUIPC: begin ASel = 1'b1; BSel = 1'b1; ImmSel = IMM_U; end
                    default: ;
                endcase
            end

            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        IRWrite    = 1'b1;
                        next_state = DECODE;
                    end
                end
                DECODE: begin
                    if (cls == C_BAD) begin
                        illegal    = 1'b1;
                        PCWrite    = 1'b1;
                        retire     = 1'b1;
                        next_state = FETCH;
                    end else begin
                        next_state = EXEC;
                    end
                end
                EXEC: begin
                    case (cls)
                        C_B: begin
                            BrUn       = funct3[1];
                            PCWrite    = 1'b1;
                            PCSel      = taken;
                            retire     = 1'b1;
                            next_state = FETCH;
                        end
                        C_LOAD, C_S: next_state = MEM;
                        default:     next_state = WB;
                    endcase
                end
                MEM: begin
                    mem_req = 1'b1;
                    MemRW   = (cls == C_S);
                    if (mem_ready) begin
                        if (cls == C_S) begin
                            PCWrite    = 1'b1;
                            retire     = 1'b1;
                            next_state = FETCH;
                        end else begin
                            next_state = WB;
                        end
                    end
                end
                WB: begin
                    RegWEn     = 1'b1;
                    PCWrite    = 1'b1;
                    retire     = 1'b1;
                    next_state = FETCH;
                    if (cls == C_LOAD) begin
                        WBSel = 2'd0;
                    end else if (cls == C_JAL || cls == C_JALR) begin
                        WBSel = 2'd2;
                        PCSel = 1'b1;
                    end else begin
                        WBSel = 2'd1;
                    end
                end
                default: next_state = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= state_t'(RESET_STATE);
            instret <= '0;
        end else begin
            state <= next_state;
            if (retire)
                instret <= instret + ONE;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-instruction expected output traces
// built from the phase rules of each instruction class, compared cycle by cycle.
module tb_multicycle_control_fsm;

    // Narrow counter so the wrap from all-ones is reachable in a short run
    localparam int IW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   inst = 32'h0;
    logic          BrEq = 1'b0, BrLt = 1'b0, mem_ready = 1'b0;
    logic          mem_req, IRWrite, PCWrite, PCSel, RegWEn, BrUn, ASel, BSel, MemRW, illegal;
    logic [1:0]    WBSel;
    logic [2:0]    ImmSel;
    logic [3:0]    ALUSel;
    logic [IW-1:0] instret;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.RESET_STATE(3'd0), .INSTRET_W(IW)) dut (
        .clk(clk), .rst(rst), .inst(inst), .BrEq(BrEq), .BrLt(BrLt),
        .mem_ready(mem_ready), .mem_req(mem_req), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .PCSel(PCSel), .RegWEn(RegWEn), .BrUn(BrUn),
        .ASel(ASel), .BSel(BSel), .MemRW(MemRW), .WBSel(WBSel),
        .ImmSel(ImmSel), .ALUSel(ALUSel), .illegal(illegal), .instret(instret)
    );

    typedef struct packed {
        logic       mem_req, ir_write, pc_write, pc_sel, reg_wen, br_un, a_sel, b_sel, mem_rw;
        logic [1:0] wb_sel;
        logic [2:0] imm_sel;
        logic [3:0] alu_sel;
        logic       illegal;
    } out_t;

    typedef struct {
        logic rdy;
        out_t o;
    } step_t;

    localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_S = 3, K_B = 4;
    localparam int K_JAL = 5, K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_BAD = 9;

    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] LW   = 32'h0000A183;
    localparam logic [31:0] BNE  = 32'h00209463;
    localparam logic [31:0] BLTU = 32'h0020E463;
    localparam logic [31:0] JAL  = 32'h008000EF;
    localparam logic [31:0] BAD  = 32'h0000007F;

    int            checks = 0, failures = 0;
    logic [IW-1:0] model_ret = '0;

    function automatic int kind(input logic [31:0] in);
        case (in[6:2])
            5'b01100: return K_R;
            5'b00100: return K_I;
            5'b00000: return K_LOAD;
            5'b01000: return K_S;
            5'b11000: return K_B;
            5'b11011: return K_JAL;
            5'b11001: return K_JALR;
            5'b01101: return K_LUI;
            5'b00101: return K_AUIPC;
            default:  return K_BAD;
        endcase
    endfunction

    // Mnemonic table: ADD/SUB SLL SLT SLTU XOR SRL/SRA OR AND
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0: return alt ? 4'd1 : 4'd0;
            3'd1: return 4'd2;
            3'd2: return 4'd3;
            3'd3: return 4'd4;
            3'd4: return 4'd5;
            3'd5: return alt ? 4'd7 : 4'd6;
            3'd6: return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    function automatic out_t sel_of(input logic [31:0] in);
        out_t s = '0;
        case (kind(in))
            K_R:     s.alu_sel = alu_of(in[14:12], in[30]);
            K_I:     begin s.alu_sel = alu_of(in[14:12], in[14:12] == 3'd5 && in[30]); s.b_sel = 1; end
            K_LOAD:  begin s.b_sel = 1; s.imm_sel = 3'd0; end
            K_S:     begin s.b_sel = 1; s.imm_sel = 3'd1; end
            K_B:     begin s.a_sel = 1; s.b_sel = 1; s.imm_sel = 3'd2; end
            K_JAL:   begin s.a_sel = 1; s.b_sel = 1; s.imm_sel = 3'd4; end
            K_JALR:  begin s.b_sel = 1; s.imm_sel = 3'd0; end
            K_LUI:   begin s.b_sel = 1; s.imm_sel = 3'd3; s.alu_sel = 4'd10; end
            K_AUIPC: begin s.a_sel = 1; s.b_sel = 1; s.imm_sel = 3'd3; end
            default: ;
        endcase
        return s;
    endfunction

    function automatic logic taken_of(input logic [2:0] f3, input logic beq, input logic blt);
        case (f3)
            3'd0:       return beq;   // BEQ
            3'd1:       return !beq;  // BNE
            3'd4, 3'd6: return blt;   // BLT/BLTU
            default:    return !blt;  // BGE/BGEU
        endcase
    endfunction

    function automatic logic rbit();
        return ($urandom & 32'd1) != 0;
    endfunction

    // Expected cycle-by-cycle trace of one instruction, with the mem_ready to drive
    task automatic build(input logic [31:0] in, input int fw, input int mw,
                         input logic beq, input logic blt, output step_t q[$]);
        step_t s;
        out_t  sel = sel_of(in);
        int    k = kind(in);
        q = {};
        for (int i = 0; i < fw; i++) begin
            s.rdy = 0; s.o = '0; s.o.mem_req = 1; q.push_back(s);
        end
        s.rdy = 1; s.o = '0; s.o.mem_req = 1; s.o.ir_write = 1; q.push_back(s);
        s.rdy = rbit(); s.o = '0;
        if (k == K_BAD) begin
            s.o.illegal = 1; s.o.pc_write = 1; q.push_back(s);
            return;
        end
        q.push_back(s);
        s.rdy = rbit(); s.o = sel;
        if (k == K_B) begin
            s.o.br_un = in[13]; s.o.pc_write = 1; s.o.pc_sel = taken_of(in[14:12], beq, blt);
            q.push_back(s);
            return;
        end
        q.push_back(s);
        if (k == K_LOAD || k == K_S) begin
            s.o = sel; s.o.mem_req = 1; s.o.mem_rw = (k == K_S);
            for (int i = 0; i < mw; i++) begin
                s.rdy = 0; q.push_back(s);
            end
            s.rdy = 1;
            if (k == K_S) begin
                s.o.pc_write = 1; q.push_back(s);
                return;
            end
            q.push_back(s);
        end
        s.rdy = rbit(); s.o = sel; s.o.reg_wen = 1; s.o.pc_write = 1;
        s.o.wb_sel = (k == K_LOAD) ? 2'd0 : (k == K_JAL || k == K_JALR) ? 2'd2 : 2'd1;
        s.o.pc_sel = (k == K_JAL || k == K_JALR);
        q.push_back(s);
    endtask

    function automatic out_t observe();
        out_t o;
        o.mem_req = mem_req; o.ir_write = IRWrite; o.pc_write = PCWrite; o.pc_sel = PCSel;
        o.reg_wen = RegWEn; o.br_un = BrUn; o.a_sel = ASel; o.b_sel = BSel; o.mem_rw = MemRW;
        o.wb_sel = WBSel; o.imm_sel = ImmSel; o.alu_sel = ALUSel; o.illegal = illegal;
        return o;
    endfunction

    // Called at posedge+1; applies each step's mem_ready and samples on the negedge
    task automatic drive(input logic [31:0] in, input logic beq, input logic blt,
                         input step_t q[$], output out_t obs[$]);
        inst = in; BrEq = beq; BrLt = blt; obs = {};
        foreach (q[i]) begin
            mem_ready = q[i].rdy;
            @(negedge clk);
            obs.push_back(observe());
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1; mem_ready = 1; inst = ADD;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (observe() !== out_t'(0)) begin
                failures++; $display("FAIL reset_outputs cyc=%0d got=%h want=0", i, observe());
            end
            @(posedge clk); #1;
        end
        checks++;
        if (instret !== '0) begin failures++; $display("FAIL reset_instret got=%h want=0", instret); end
        rst = 0; mem_ready = 0; model_ret = '0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || IRWrite !== 1'b0) begin
            failures++; $display("FAIL reset_first_fetch got mem_req=%b IRWrite=%b want 1/0", mem_req, IRWrite);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        step_t q[$]; out_t obs[$];
        build(ADD, 0, 0, 0, 0, q);
        drive(ADD, 0, 0, q, obs);
        for (int i = 0; i < q.size(); i++) begin
            checks++;
            if (obs[i] !== q[i].o) begin failures++; $display("FAIL add cyc=%0d got=%h want=%h", i, obs[i], q[i].o); end
        end
        model_ret = model_ret + 1'b1;
        checks++;
        if (instret !== model_ret) begin failures++; $display("FAIL add_instret got=%0d want=%0d", instret, model_ret); end
    endtask

    task automatic test_lw_wait();
        step_t q[$]; out_t obs[$];
        build(LW, 0, 3, 0, 0, q);
        drive(LW, 0, 0, q, obs);
        for (int i = 0; i < q.size(); i++) begin
            checks++;
            if (obs[i] !== q[i].o) begin failures++; $display("FAIL lw_wait cyc=%0d got=%h want=%h", i, obs[i], q[i].o); end
        end
        model_ret = model_ret + 1'b1;
        checks++;
        if (instret !== model_ret) begin failures++; $display("FAIL lw_instret got=%0d want=%0d", instret, model_ret); end
    endtask

    task automatic test_branch();
        logic [31:0] ins [3] = '{BNE, BNE, BLTU};
        logic        eqs [3] = '{1'b0, 1'b1, 1'b0};
        logic        lts [3] = '{1'b0, 1'b0, 1'b1};
        for (int t = 0; t < 3; t++) begin
            step_t q[$]; out_t obs[$];
            build(ins[t], 0, 0, eqs[t], lts[t], q);
            drive(ins[t], eqs[t], lts[t], q, obs);
            for (int i = 0; i < q.size(); i++) begin
                checks++;
                if (obs[i] !== q[i].o) begin failures++; $display("FAIL branch%0d cyc=%0d got=%h want=%h", t, i, obs[i], q[i].o); end
            end
            model_ret = model_ret + 1'b1;
            checks++;
            if (instret !== model_ret) begin failures++; $display("FAIL branch%0d_instret got=%0d want=%0d", t, instret, model_ret); end
        end
    endtask

    task automatic test_jal();
        step_t q[$]; out_t obs[$];
        build(JAL, 1, 0, 0, 0, q);
        drive(JAL, 0, 0, q, obs);
        for (int i = 0; i < q.size(); i++) begin
            checks++;
            if (obs[i] !== q[i].o) begin failures++; $display("FAIL jal cyc=%0d got=%h want=%h", i, obs[i], q[i].o); end
        end
        model_ret = model_ret + 1'b1;
        checks++;
        if (instret !== model_ret) begin failures++; $display("FAIL jal_instret got=%0d want=%0d", instret, model_ret); end
    endtask

    task automatic test_illegal_wrap();
        step_t q[$]; out_t obs[$];
        while (model_ret != '1) begin
            build(BAD, 0, 0, 0, 0, q);
            drive(BAD, 0, 0, q, obs);
            model_ret = model_ret + 1'b1;
        end
        checks++;
        if (instret !== model_ret) begin failures++; $display("FAIL illegal_preload got=%h want=%h", instret, model_ret); end
        build(BAD, 2, 0, 0, 0, q);
        drive(BAD, 0, 0, q, obs);
        for (int i = 0; i < q.size(); i++) begin
            checks++;
            if (obs[i] !== q[i].o) begin failures++; $display("FAIL illegal cyc=%0d got=%h want=%h", i, obs[i], q[i].o); end
        end
        model_ret = model_ret + 1'b1;
        checks++;
        if (instret !== '0) begin failures++; $display("FAIL instret_wrap got=%h want=0", instret); end
    endtask

    task automatic test_reset_mid();
        step_t q[$], head[$]; out_t obs[$];
        build(ADD, 0, 0, 0, 0, q);
        head = q[0:2];
        drive(ADD, 0, 0, head, obs);
        rst = 1; mem_ready = 1;
        @(negedge clk);
        checks++;
        if (observe() !== out_t'(0)) begin failures++; $display("FAIL reset_mid_outputs got=%h want=0", observe()); end
        @(posedge clk); #1;
        rst = 0; model_ret = '0;
        checks++;
        if (instret !== '0) begin failures++; $display("FAIL reset_mid_instret got=%0d want=0", instret); end
        build(ADD, 0, 0, 0, 0, q);
        drive(ADD, 0, 0, q, obs);
        for (int i = 0; i < q.size(); i++) begin
            checks++;
            if (obs[i] !== q[i].o) begin failures++; $display("FAIL reset_mid_next cyc=%0d got=%h want=%h", i, obs[i], q[i].o); end
        end
        model_ret = model_ret + 1'b1;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] in = $urandom;
        logic [4:0]  ops [9] = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000,
                                 5'b11011, 5'b11001, 5'b01101, 5'b00101};
        logic [4:0]  bad [4] = '{5'h1F, 5'h03, 5'h1C, 5'h0B};
        int p = $urandom_range(0, 9);
        in[6:2] = (p == 9) ? bad[$urandom_range(0, 3)] : ops[p];
        in[1:0] = 2'b11;
        if (p == 4)
            while (in[14:13] == 2'b01) in[14:12] = 3'($urandom_range(0, 7));
        return in;
    endfunction

    task automatic test_random();
        for (int n = 0; n < 120; n++) begin
            step_t q[$]; out_t obs[$];
            logic [31:0] in = rand_inst();
            logic beq = rbit(), blt = rbit();
            build(in, $urandom_range(0, 3), $urandom_range(0, 3), beq, blt, q);
            drive(in, beq, blt, q, obs);
            for (int i = 0; i < q.size(); i++) begin
                checks++;
                if (obs[i] !== q[i].o) begin
                    failures++; $display("FAIL random inst=%h cyc=%0d got=%h want=%h", in, i, obs[i], q[i].o);
                end
            end
            model_ret = model_ret + 1'b1;
            checks++;
            if (instret !== model_ret) begin failures++; $display("FAIL random_instret inst=%h got=%0d want=%0d", in, instret, model_ret); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_branch();
        test_jal();
        test_illegal_wrap();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle RV32I control sequencer for the shared-resource datapath: one ALU, one unified instruction/data memory port, one register file.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the same datapath select signals as the single-cycle control unit.
- Adds register and PC write-enables, a memory request/ready handshake, an illegal-opcode flag and a retired-instruction counter.

Parameters:
- RESET_STATE, 3'd0, state encoding entered on reset (FETCH).
- INSTRET_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- inst  input  32  current instruction, from the external IR.
- BrEq  input  1  branch comparator: equal.
- BrLt  input  1  branch comparator: less-than, signedness per BrUn.
- mem_ready  input  1  memory has completed the current request this cycle.
- mem_req  output  1  memory access request, held until mem_ready.
- IRWrite  output  1  load the IR from memory read data.
- PCWrite  output  1  update the PC this cycle.
- PCSel  output  1  0 = PC+4, 1 = ALU result.
- RegWEn  output  1  register file write enable.
- BrUn  output  1  unsigned branch compare.
- ASel  output  1  0 = rs1, 1 = PC.
- BSel  output  1  0 = rs2, 1 = immediate.
- MemRW  output  1  0 = read, 1 = write; meaningful only while mem_req = 1.
- WBSel  output  2  writeback source: 0 = memory, 1 = ALU, 2 = PC+4.
- ImmSel  output  3  immediate format: 0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
- ALUSel  output  4  ALU operation: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
- illegal  output  1  one-cycle pulse in DECODE on an unsupported opcode.
- instret  output  INSTRET_W  count of retired instructions.

Behaviour:
- Reset:
  - Synchronous: state <= FETCH, instret <= 0.
  - While rst = 1, all enables and mem_req are forced to 0, and every select output is 0.
  - Reset mid-instruction abandons it: no PC or register write.
- Opcode classes, decoded from inst[6:2]:
  - R 01100, I 00100, LOAD 00000, S 01000, B 11000.
  - JAL 11011, JALR 11001, LUI 01101, AUIPC 00101.
- FETCH:
  - mem_req = 1, MemRW = 0.
  - Stays in FETCH while mem_ready = 0.
  - When mem_ready = 1: IRWrite = 1 that cycle, next state DECODE.
- DECODE:
  - One cycle; the register file reads settle.
  - Unknown opcode: illegal = 1, PCWrite = 1, PCSel = 0, counted as retired, next state FETCH.
  - Otherwise next state EXEC.
- EXEC: one cycle.
  - R: ALUSel from funct3 plus inst[30] (SUB/SRA).
  - I: same as R, but inst[30] is used only for SRAI; BSel = 1.
  - LOAD/S: ALU ADD, BSel = 1, ImmSel = I or S respectively.
  - B: ASel = 1, BSel = 1, ImmSel = B, ALU ADD, BrUn = funct3[1].
    - taken = BEQ: BrEq, BNE: !BrEq, BLT/BLTU: BrLt, BGE/BGEU: !BrLt.
    - PCWrite = 1, PCSel = taken; retire; next state FETCH.
  - JAL: ASel = 1, ImmSel = J. JALR: ImmSel = I. Both use ALU ADD with BSel = 1.
  - LUI: ALU PASS_B, ImmSel = U.
  - AUIPC: ASel = 1, ImmSel = U, ALU ADD.
  - Next state: MEM for LOAD and S; WB for all other non-branch classes.
- MEM:
  - mem_req = 1; MemRW = 1 for S, 0 for LOAD.
  - EXEC datapath selects are held stable.
  - Waits for mem_ready.
  - S: on mem_ready, PCWrite = 1, PCSel = 0, retire, next state FETCH.
  - LOAD: on mem_ready, next state WB.
- WB:
  - One cycle; RegWEn = 1 and PCWrite = 1.
  - WBSel = 0 for LOAD, 2 for JAL/JALR, 1 otherwise.
  - PCSel = 1 for JAL/JALR, 0 otherwise.
  - Retire; next state FETCH.
  - The PC changes at the same edge as the register write, so WBSel = 2 observes the old PC+4.
- Outputs are combinational from state, inst, BrEq and BrLt.
  - Outside the states that use them, the select outputs are 0.
  - RegWEn, PCWrite, IRWrite and mem_req are 1 only where specified above.
- Retirement and instret:
  - Retire means instret increments by 1 at that edge, exactly once per instruction.
  - instret wraps from all-ones to 0.
- Zero-wait-state latency in cycles:
  - B: 3; S: 4; R/I/JAL/JALR/LUI/AUIPC: 4; LOAD: 5; illegal: 2.

Test Plan:
- Reset: assert rst for 2 cycles with mem_ready = 1 → mem_req = 0, PCWrite = 0, instret = 0. Release → FETCH with mem_req = 1 on the first cycle.
- `add x3,x1,x2` (0x002081B3), mem_ready = 1 → IRWrite at cycle 1. WB at cycle 4 with RegWEn = 1, WBSel = 1, ALUSel = 0, BSel = 0. instret = 1.
- `lw` (0x0000A183) with mem_ready low for 3 cycles in MEM → mem_req held, MemRW = 0, no writes. WB follows with WBSel = 0. Total 8 cycles.
- `bne` (0x00209463):
  - BrEq = 0 → EXEC has PCWrite = 1, PCSel = 1, BrUn = 0, RegWEn = 0.
  - Repeat with BrEq = 1 → PCSel = 0.
  - `bltu` → BrUn = 1.
- `jal` (0x008000EF) → EXEC: ASel = 1, ImmSel = 4. WB: RegWEn = 1, WBSel = 2, PCSel = 1, PCWrite = 1.
- Opcode 0x0000007F → illegal pulse in DECODE, PC+4, instret increments. Preload instret to 0xFFFFFFFF → wraps to 0.
